// File: rtl/pos_cell_streamer.sv
// Drains one cell position memory (count at addr 0, positions at 1..N) into a valid/ready stream.
// Optional macro POS_STREAMER_CLAMP_EN clamps corrupted counts and adds the count_err output.
module pos_cell_streamer #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_pid,
  output logic                  out_last
`ifdef POS_STREAMER_CLAMP_EN
  , output logic                count_err
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_N = ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef enum logic [2:0] {IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic                  wait_q, wait_d;
  logic [ADDR_WIDTH-1:0] n_q, n_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            rv_q, rv_d;
  logic [ADDR_WIDTH-1:0] tag0_q, tag0_d, tag1_q, tag1_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pid_q  [FIFO_DEPTH];

  logic                  push, pop, issue, n_err;
  logic [CW:0]           occupancy;
  logic [ADDR_WIDTH-1:0] n_eff;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef POS_STREAMER_CLAMP_EN
  logic err_q, err_d;
  assign n_err     = (mem_q[ADDR_WIDTH-1:0] > MAX_N);
  assign n_eff     = n_err ? MAX_N : mem_q[ADDR_WIDTH-1:0];
  assign count_err = err_q;
`else
  assign n_err = 1'b0;
  assign n_eff = mem_q[ADDR_WIDTH-1:0];
`endif

  assign out_valid      = (cnt_q != '0);
  assign out_data       = out_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign out_pid        = out_valid ? fifo_pid_q[rd_ptr_q] : '0;
  assign out_last       = out_valid && (fifo_pid_q[rd_ptr_q] == n_q);
  assign particle_count = n_q;
  assign mem_wren       = 1'b0;

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    n_d      = n_q;
    addr_d   = addr_q;
`ifdef POS_STREAMER_CLAMP_EN
    err_d    = err_q;
`endif
    issue    = 1'b0;
    mem_rden = 1'b0;
    mem_addr = '0;
    busy     = 1'b0;
    done     = 1'b0;

    // Data enters the FIFO when the second stage of the read-valid pipe is set.
    push      = rv_q[1];
    pop       = out_valid && out_ready;
    occupancy = (CW+1)'(rv_q[0]) + (CW+1)'(rv_q[1]) + (CW+1)'(cnt_q);
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
    wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD_CNT;
          n_d     = '0;
`ifdef POS_STREAMER_CLAMP_EN
          err_d   = 1'b0;
`endif
        end
      end
      RD_CNT: begin
        busy     = 1'b1;
        mem_rden = 1'b1;
        wait_d   = 1'b0;
        state_d  = WAIT_CNT;
      end
      WAIT_CNT: begin
        busy = 1'b1;
        if (wait_q) begin
          n_d     = n_eff;
          addr_d  = ADDR_WIDTH'(1);
`ifdef POS_STREAMER_CLAMP_EN
          err_d   = n_err;
`endif
          state_d = (n_eff == '0) ? DONE : STREAM;
        end else begin
          wait_d = 1'b1;
        end
      end
      STREAM: begin
        busy = 1'b1;
        // Credit: reads still in flight reserve a slot so a push never finds the FIFO full.
        if (occupancy < (CW+1)'(FIFO_DEPTH)) begin
          issue    = 1'b1;
          mem_rden = 1'b1;
          mem_addr = addr_q;
          addr_d   = addr_q + 1'b1;
          if (addr_q == n_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (!rv_q[0] && !rv_q[1] && cnt_d == '0) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rv_d   = {rv_q[0], issue};
    tag0_d = issue ? addr_q : tag0_q;
    tag1_d = tag0_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wait_q   <= 1'b0;
      n_q      <= '0;
      addr_q   <= '0;
      rv_q     <= '0;
      tag0_q   <= '0;
      tag1_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
`ifdef POS_STREAMER_CLAMP_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      n_q      <= n_d;
      addr_q   <= addr_d;
      rv_q     <= rv_d;
      tag0_q   <= tag0_d;
      tag1_q   <= tag1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
`ifdef POS_STREAMER_CLAMP_EN
      err_q    <= err_d;
`endif
    end
  end

  // Storage needs no reset: outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_data_q[wr_ptr_q] <= mem_q;
      fifo_pid_q[wr_ptr_q]  <= tag1_q;
    end
  end

endmodule
